fetch_unit: RTL

Parametrised instruction-fetch stage with a decoupling instruction queue, static predecode and predictor-steered next-PC selection. It sits between the ICache and the decoder. It keeps one outstanding ICache request, buffers fetched instructions with their PC and prediction bit, and discards all in-flight work when the ROB signals a misprediction.

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding ICache requester, static
// predecode of JAL/branch targets, and a circular instruction queue that
// feeds the decoder. A ROB flush redirects the PC and empties the queue.
module fetch_unit #(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_W     = 32,
    parameter int                QUEUE_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  flush_pc_i,
    output logic               icache_req_o,
    output logic [ADDR_W-1:0]  icache_addr_o,
    input  logic               icache_valid_i,
    input  logic [INSTR_W-1:0] icache_data_i,
    output logic [ADDR_W-1:0]  pred_pc_o,
    input  logic               pred_taken_i,
    output logic               dec_valid_o,
    output logic [INSTR_W-1:0] dec_instr_o,
    output logic [ADDR_W-1:0]  dec_pc_o,
    output logic               dec_pred_taken_o,
    input  logic               dec_ready_i
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]         state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic               req_nx;
    logic [ADDR_W-1:0]  addr_nx;

    logic [INSTR_W-1:0] q_instr [QUEUE_DEPTH];
    logic [ADDR_W-1:0]  q_pc    [QUEUE_DEPTH];
    logic               q_taken [QUEUE_DEPTH];

    logic [PTR_W-1:0]   head, tail, head_nx, tail_nx;
    logic [CNT_W-1:0]   count, count_nx, cnt_after_deq;
    logic               enq, deq;

    logic signed [ADDR_W-1:0] j_imm, b_imm;
    logic [ADDR_W-1:0]  seq_pc;
    logic               seq_taken;

    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               head_taken;

    // Predictor sees the address of the outstanding request.
    assign pred_pc_o = icache_addr_o;

    assign j_imm = {{(ADDR_W-21){icache_data_i[31]}}, icache_data_i[31], icache_data_i[19:12],
                    icache_data_i[20], icache_data_i[30:21], 1'b0};
    assign b_imm = {{(ADDR_W-13){icache_data_i[31]}}, icache_data_i[31], icache_data_i[7],
                    icache_data_i[30:25], icache_data_i[11:8], 1'b0};

    // Next-PC selection from the opcode of the returning instruction.
    always_comb begin
        seq_pc    = pc + ADDR_W'(4);
        seq_taken = 1'b0;
        if (icache_data_i[6:0] == OP_JAL) begin
            seq_pc    = pc + $unsigned(j_imm);
            seq_taken = 1'b1;
        end else if (icache_data_i[6:0] == OP_BRANCH && pred_taken_i) begin
            seq_pc    = pc + $unsigned(b_imm);
            seq_taken = 1'b1;
        end
    end

    // Request FSM: issue, wait for response, or discard a stale response.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        req_nx   = icache_req_o;
        addr_nx  = icache_addr_o;
        case (state)
            IDLE: begin
                if (flush_i) begin
                    pc_nx = flush_pc_i;
                end else if (count != FULL) begin
                    state_nx = WAIT;
                    req_nx   = 1'b1;
                    addr_nx  = pc;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    pc_nx    = flush_pc_i;
                    req_nx   = 1'b0;
                    state_nx = icache_valid_i ? IDLE : DROP;
                end else if (icache_valid_i) begin
                    pc_nx    = seq_pc;
                    req_nx   = 1'b0;
                    state_nx = IDLE;
                end
            end
            DROP: begin
                req_nx = 1'b0;
                if (flush_i) pc_nx = flush_pc_i;
                // The stale response is consumed here whether or not a
                // further flush arrives with it, so nothing stays pending.
                if (icache_valid_i) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
            end
        endcase
    end

    assign enq = (state == WAIT) && icache_valid_i && !flush_i;
    assign deq = dec_valid_o && dec_ready_i && !flush_i;
    assign cnt_after_deq = count - CNT_W'(deq);

    // Queue pointer/count update and the entry that becomes the new head.
    always_comb begin
        if (flush_i) begin
            head_nx  = '0;
            tail_nx  = '0;
            count_nx = '0;
        end else begin
            head_nx  = head + PTR_W'(deq);
            tail_nx  = tail + PTR_W'(enq);
            count_nx = cnt_after_deq + CNT_W'(enq);
        end
        // An entry written into an otherwise empty queue is the head itself.
        if (enq && cnt_after_deq == '0) begin
            head_instr = icache_data_i;
            head_pc    = pc;
            head_taken = seq_taken;
        end else begin
            head_instr = q_instr[head_nx];
            head_pc    = q_pc[head_nx];
            head_taken = q_taken[head_nx];
        end
    end

    // Queue storage; written only on a real enqueue.
    always_ff @(posedge clk) begin
        if (!rst && rdy && enq) begin
            q_instr[tail] <= icache_data_i;
            q_pc[tail]    <= pc;
            q_taken[tail] <= seq_taken;
        end
    end

    // Architectural state and registered outputs, frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            icache_req_o     <= 1'b0;
            icache_addr_o    <= RESET_PC;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            dec_valid_o      <= 1'b0;
            dec_instr_o      <= '0;
            dec_pc_o         <= '0;
            dec_pred_taken_o <= 1'b0;
        end else if (rdy) begin
            state            <= state_nx;
            pc               <= pc_nx;
            icache_req_o     <= req_nx;
            icache_addr_o    <= addr_nx;
            head             <= head_nx;
            tail             <= tail_nx;
            count            <= count_nx;
            dec_valid_o      <= (count_nx != '0);
            dec_instr_o      <= head_instr;
            dec_pc_o         <= head_pc;
            dec_pred_taken_o <= head_taken;
        end
    end

endmodule
